// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: ALU opcodes, arbiter state codes
// and requester (owner) ids.
package alu_arbiter_pkg;

    localparam int ALU_OP_W = 5;

    // ALU opcodes understood by the shared core ALU
    localparam logic [ALU_OP_W-1:0] ALU_PLUS  = 5'd0;
    localparam logic [ALU_OP_W-1:0] ALU_MINUS = 5'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND   = 5'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR    = 5'd3;
    localparam logic [ALU_OP_W-1:0] ALU_BEQ   = 5'd4;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_FFT  = 1'b1
    } req_id_e;

endpackage

// File: rtl/alu_arbiter_grant.sv
// Grant decision for the shared ALU: core priority, FFT starvation guard
// and a bounded FFT burst lock. Ready is only ever offered to one side.
module alu_arb_grant
    import alu_arbiter_pkg::*;
#(
    parameter int STARVE_LIM = 4,
    parameter int LOCK_MAX   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic c_valid,
    input  logic f_valid,
    input  logic f_lock,
    input  logic accept_ok,
    output logic c_ready,
    output logic f_ready
);

    localparam int STARVE_W = $clog2(STARVE_LIM + 1);
    localparam int LOCK_W   = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

    arb_state_e          state_q, state_d;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic                c_grant, f_grant, c_fire, f_fire;
    logic                starved, lock_expired;

    // Pick the granted side, then update the FSM and both counters
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        lock_cnt_d   = lock_cnt_q;
        c_grant      = 1'b0;
        f_grant      = 1'b0;
        starved      = (starve_cnt_q == STARVE_W'(STARVE_LIM));
        lock_expired = (lock_cnt_q == LOCK_W'(LOCK_MAX - 1));

        if (state_q == ARB_LOCK) begin
            f_grant = 1'b1;
        end else if (f_valid && (!c_valid || starved)) begin
            f_grant = 1'b1;
        end else if (c_valid) begin
            c_grant = 1'b1;
        end

        c_ready = c_grant && accept_ok;
        f_ready = f_grant && accept_ok;
        c_fire  = c_valid && c_ready;
        f_fire  = f_valid && f_ready;

        if (f_fire) begin
            starve_cnt_d = '0;
        end else if ((state_q == ARB_IDLE) && c_fire && f_valid && !starved) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end

        case (state_q)
            ARB_IDLE: begin
                if (f_fire && f_lock) begin
                    state_d    = ARB_LOCK;
                    lock_cnt_d = '0;
                end
            end
            ARB_LOCK: begin
                lock_cnt_d = lock_cnt_q + 1'b1;
                if (lock_expired || (f_fire && !f_lock)) begin
                    state_d    = ARB_IDLE;
                    lock_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ARB_IDLE;
                lock_cnt_d = '0;
            end
        endcase
    end

    // Arbiter state and counters, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            starve_cnt_q <= '0;
            lock_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            lock_cnt_q   <= lock_cnt_d;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares the core ALU between the RV32 execute stage (core) and the FFT
// butterfly sequencer through an issue register and a result register.
// Optional statistics counters are compiled in with ALU_ARB_STATS_EN.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int OP_W       = 5,
    parameter int STARVE_LIM = 4,
    parameter int LOCK_MAX   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              c_valid,
    output logic              c_ready,
    input  logic [OP_W-1:0]   c_op,
    input  logic [DATA_W-1:0] c_src1,
    input  logic [DATA_W-1:0] c_src2,
    input  logic [DATA_W-1:0] c_pc,
    output logic              c_rsp_valid,
    input  logic              c_rsp_ready,
    input  logic              f_valid,
    output logic              f_ready,
    input  logic [OP_W-1:0]   f_op,
    input  logic [DATA_W-1:0] f_src1,
    input  logic [DATA_W-1:0] f_src2,
    input  logic [DATA_W-1:0] f_pc,
    output logic              f_rsp_valid,
    input  logic              f_rsp_ready,
    input  logic              f_lock,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_src1,
    output logic [DATA_W-1:0] alu_src2,
    output logic [DATA_W-1:0] alu_pc,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [31:0]       stat_c_cnt,
    output logic [31:0]       stat_f_cnt,
    output logic [31:0]       stat_stall_cnt
`endif
);

    logic              iss_v_q, iss_v_d;
    req_id_e           iss_owner_q, iss_owner_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic [DATA_W-1:0] alu_src1_q, alu_src1_d;
    logic [DATA_W-1:0] alu_src2_q, alu_src2_d;
    logic [DATA_W-1:0] alu_pc_q, alu_pc_d;
    logic              rsp_v_q, rsp_v_d;
    req_id_e           rsp_owner_q, rsp_owner_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_zero_q, rsp_zero_d;
    logic              owner_rsp_ready, s2_free, s1_adv, accept_ok;
    logic              c_fire, f_fire;

    // Pipeline flow control; ready is held low while reset is asserted
    always_comb begin
        owner_rsp_ready = (rsp_owner_q == REQ_FFT) ? f_rsp_ready : c_rsp_ready;
        s2_free         = !rsp_v_q || owner_rsp_ready;
        s1_adv          = iss_v_q && s2_free;
        accept_ok       = rst_n && (!iss_v_q || s1_adv);
        c_fire          = c_valid && c_ready;
        f_fire          = f_valid && f_ready;
    end

    alu_arb_grant #(
        .STARVE_LIM (STARVE_LIM),
        .LOCK_MAX   (LOCK_MAX)
    ) u_grant (
        .clk       (clk),
        .rst_n     (rst_n),
        .c_valid   (c_valid),
        .f_valid   (f_valid),
        .f_lock    (f_lock),
        .accept_ok (accept_ok),
        .c_ready   (c_ready),
        .f_ready   (f_ready)
    );

    // Issue register loads the accepted request or empties when it advances
    always_comb begin
        iss_v_d     = iss_v_q;
        iss_owner_d = iss_owner_q;
        alu_op_d    = alu_op_q;
        alu_src1_d  = alu_src1_q;
        alu_src2_d  = alu_src2_q;
        alu_pc_d    = alu_pc_q;
        if (c_fire) begin
            iss_v_d     = 1'b1;
            iss_owner_d = REQ_CORE;
            alu_op_d    = c_op;
            alu_src1_d  = c_src1;
            alu_src2_d  = c_src2;
            alu_pc_d    = c_pc;
        end else if (f_fire) begin
            iss_v_d     = 1'b1;
            iss_owner_d = REQ_FFT;
            alu_op_d    = f_op;
            alu_src1_d  = f_src1;
            alu_src2_d  = f_src2;
            alu_pc_d    = f_pc;
        end else if (s1_adv) begin
            iss_v_d = 1'b0;
        end
    end

    // Result register captures the ALU output and holds it until consumed
    always_comb begin
        rsp_v_d     = rsp_v_q;
        rsp_owner_d = rsp_owner_q;
        rsp_data_d  = rsp_data_q;
        rsp_zero_d  = rsp_zero_q;
        if (s1_adv) begin
            rsp_v_d     = 1'b1;
            rsp_owner_d = iss_owner_q;
            rsp_data_d  = alu_result;
            rsp_zero_d  = alu_zero;
        end else if (rsp_v_q && owner_rsp_ready) begin
            rsp_v_d = 1'b0;
        end
    end

    // Pipeline registers; reset drops anything in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            iss_v_q     <= 1'b0;
            iss_owner_q <= REQ_CORE;
            alu_op_q    <= OP_W'(ALU_PLUS);
            alu_src1_q  <= '0;
            alu_src2_q  <= '0;
            alu_pc_q    <= '0;
            rsp_v_q     <= 1'b0;
            rsp_owner_q <= REQ_CORE;
            rsp_data_q  <= '0;
            rsp_zero_q  <= 1'b0;
        end else begin
            iss_v_q     <= iss_v_d;
            iss_owner_q <= iss_owner_d;
            alu_op_q    <= alu_op_d;
            alu_src1_q  <= alu_src1_d;
            alu_src2_q  <= alu_src2_d;
            alu_pc_q    <= alu_pc_d;
            rsp_v_q     <= rsp_v_d;
            rsp_owner_q <= rsp_owner_d;
            rsp_data_q  <= rsp_data_d;
            rsp_zero_q  <= rsp_zero_d;
        end
    end

    assign alu_op      = alu_op_q;
    assign alu_src1    = alu_src1_q;
    assign alu_src2    = alu_src2_q;
    assign alu_pc      = alu_pc_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_zero    = rsp_zero_q;
    assign c_rsp_valid = rsp_v_q && (rsp_owner_q == REQ_CORE);
    assign f_rsp_valid = rsp_v_q && (rsp_owner_q == REQ_FFT);

`ifdef ALU_ARB_STATS_EN
    logic [31:0] stat_c_q, stat_c_d;
    logic [31:0] stat_f_q, stat_f_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    // Accept counts per side and stall cycles, wrapping at 2^32
    always_comb begin
        stat_c_d     = stat_c_q + {31'd0, c_fire};
        stat_f_d     = stat_f_q + {31'd0, f_fire};
        stat_stall_d = stat_stall_q + {31'd0, (iss_v_q && !s2_free)};
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_c_q     <= '0;
            stat_f_q     <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_c_q     <= stat_c_d;
            stat_f_q     <= stat_f_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_c_cnt     = stat_c_q;
    assign stat_f_cnt     = stat_f_q;
    assign stat_stall_cnt = stat_stall_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: table-driven ALU vectors plus
// hand-written arbitration, lock, backpressure and reset sequences.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        c_valid, c_ready, c_rsp_valid, c_rsp_ready;
    logic [4:0]  c_op;
    logic [31:0] c_src1, c_src2, c_pc;
    logic        f_valid, f_ready, f_rsp_valid, f_rsp_ready, f_lock;
    logic [4:0]  f_op;
    logic [31:0] f_src1, f_src2, f_pc;
    logic [4:0]  alu_op;
    logic [31:0] alu_src1, alu_src2, alu_pc, alu_result, rsp_data;
    logic        alu_zero, rsp_zero;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        is_f;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_data;
        logic        exp_zero;
        logic        care_data;
    } vec_t;

    vec_t vecs[8];
    bit   exp_f[12];

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .c_valid     (c_valid),
        .c_ready     (c_ready),
        .c_op        (c_op),
        .c_src1      (c_src1),
        .c_src2      (c_src2),
        .c_pc        (c_pc),
        .c_rsp_valid (c_rsp_valid),
        .c_rsp_ready (c_rsp_ready),
        .f_valid     (f_valid),
        .f_ready     (f_ready),
        .f_op        (f_op),
        .f_src1      (f_src1),
        .f_src2      (f_src2),
        .f_pc        (f_pc),
        .f_rsp_valid (f_rsp_valid),
        .f_rsp_ready (f_rsp_ready),
        .f_lock      (f_lock),
        .alu_op      (alu_op),
        .alu_src1    (alu_src1),
        .alu_src2    (alu_src2),
        .alu_pc      (alu_pc),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .rsp_data    (rsp_data),
        .rsp_zero    (rsp_zero)
    );

    // Stand-in for the external core ALU
    always_comb begin
        case (alu_op)
            ALU_PLUS:  alu_result = alu_src1 + alu_src2;
            ALU_MINUS: alu_result = alu_src1 - alu_src2;
            ALU_AND:   alu_result = alu_src1 & alu_src2;
            ALU_OR:    alu_result = alu_src1 | alu_src2;
            ALU_BEQ:   alu_result = alu_src1 - alu_src2;
            default:   alu_result = 32'd0;
        endcase
        if (alu_op == ALU_BEQ) alu_zero = (alu_src1 == alu_src2);
        else                   alu_zero = (alu_result == 32'd0);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkFlag(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic cv, input logic [4:0] cop, input logic [31:0] ca,
                                 input logic [31:0] cb, input logic fv, input logic [4:0] fop,
                                 input logic [31:0] fa, input logic [31:0] fb, input logic flk);
        c_valid = cv;  c_op = cop; c_src1 = ca; c_src2 = cb; c_pc = 32'h0000_0100;
        f_valid = fv;  f_op = fop; f_src1 = fa; f_src2 = fb; f_pc = 32'h0000_0200;
        f_lock  = flk;
    endtask

    task automatic idle();
        applyStimulus(1'b0, ALU_PLUS, 32'd0, 32'd0, 1'b0, ALU_PLUS, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        idle();
        c_rsp_ready = 1'b1;
        f_rsp_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{1'b0, ALU_PLUS,  32'd5,         32'd7,         32'd12,        1'b0, 1'b1};
        vecs[1] = '{1'b1, ALU_MINUS, 32'd10,        32'd3,         32'd7,         1'b0, 1'b1};
        vecs[2] = '{1'b0, ALU_AND,   32'h0000_00F0, 32'h0000_003C, 32'h0000_0030, 1'b0, 1'b1};
        vecs[3] = '{1'b1, ALU_OR,    32'h0000_0F00, 32'h0000_00F0, 32'h0000_0FF0, 1'b0, 1'b1};
        vecs[4] = '{1'b0, ALU_MINUS, 32'd4,         32'd4,         32'd0,         1'b1, 1'b1};
        vecs[5] = '{1'b1, ALU_PLUS,  32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1, 1'b1};
        vecs[6] = '{1'b0, ALU_BEQ,   32'd9,         32'd9,         32'd0,         1'b1, 1'b0};
        vecs[7] = '{1'b1, ALU_BEQ,   32'd9,         32'd8,         32'd0,         1'b0, 1'b0};
        exp_f   = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};

        // Reset state
        resetDut();
        #1;
        checkOutput("reset_alu_op", {27'd0, alu_op}, {27'd0, ALU_PLUS});
        checkOutput("reset_alu_src1", alu_src1, 32'd0);
        checkOutput("reset_alu_pc", alu_pc, 32'd0);
        checkOutput("reset_rsp_data", rsp_data, 32'd0);
        checkFlag("reset_c_rsp_valid", c_rsp_valid, 1'b0);
        checkFlag("reset_f_rsp_valid", f_rsp_valid, 1'b0);
        checkFlag("reset_f_ready", f_ready, 1'b0);

        // Core only: 5+7, two-stage latency, FFT never offered ready
        applyStimulus(1'b1, ALU_PLUS, 32'd5, 32'd7, 1'b0, ALU_PLUS, 32'd0, 32'd0, 1'b0);
        #1;
        checkFlag("t1_c_ready", c_ready, 1'b1);
        checkFlag("t1_f_ready0", f_ready, 1'b0);
        step();
        idle();
        #1;
        checkOutput("t1_alu_src1", alu_src1, 32'd5);
        checkOutput("t1_alu_src2", alu_src2, 32'd7);
        checkOutput("t1_alu_pc", alu_pc, 32'h0000_0100);
        checkFlag("t1_rsp_early", c_rsp_valid, 1'b0);
        step();
        #1;
        checkFlag("t1_c_rsp_valid", c_rsp_valid, 1'b1);
        checkOutput("t1_rsp_data", rsp_data, 32'd12);
        checkFlag("t1_f_ready1", f_ready, 1'b0);
        step();

        // Table-driven vectors, back-to-back, alternating sides
        resetDut();
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                if (vecs[i].is_f)
                    applyStimulus(1'b0, ALU_PLUS, 32'd0, 32'd0, 1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
                else
                    applyStimulus(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, ALU_PLUS, 32'd0, 32'd0, 1'b0);
            end else begin
                idle();
            end
            #1;
            if (i < 8) checkFlag($sformatf("vec%0d_ready", i), vecs[i].is_f ? f_ready : c_ready, 1'b1);
            if (i >= 2) begin
                checkFlag($sformatf("vec%0d_c_rsp_valid", i - 2), c_rsp_valid, !vecs[i-2].is_f);
                checkFlag($sformatf("vec%0d_f_rsp_valid", i - 2), f_rsp_valid, vecs[i-2].is_f);
                checkFlag($sformatf("vec%0d_zero", i - 2), rsp_zero, vecs[i-2].exp_zero);
                if (vecs[i-2].care_data)
                    checkOutput($sformatf("vec%0d_data", i - 2), rsp_data, vecs[i-2].exp_data);
            end
            step();
        end

        // Starvation guard then an F burst with f_lock 1,1,1,0, C always valid
        resetDut();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, ALU_PLUS, i, 32'd0, 1'b1, ALU_PLUS, 100 + i, 32'd0, i < 7);
            #1;
            checkFlag($sformatf("arb%0d_c_ready", i), c_ready, !exp_f[i]);
            checkFlag($sformatf("arb%0d_f_ready", i), f_ready, exp_f[i]);
            if (i >= 2) begin
                checkFlag($sformatf("arb%0d_f_rsp", i), f_rsp_valid, exp_f[i-2]);
                checkFlag($sformatf("arb%0d_c_rsp", i), c_rsp_valid, !exp_f[i-2]);
                checkOutput($sformatf("arb%0d_data", i), rsp_data,
                            exp_f[i-2] ? 32'(100 + i - 2) : 32'(i - 2));
            end
            step();
        end

        // Lock held continuously: forced release after LOCK_MAX cycles
        resetDut();
        applyStimulus(1'b0, ALU_PLUS, 32'd0, 32'd0, 1'b1, ALU_PLUS, 32'd1, 32'd1, 1'b1);
        #1;
        checkFlag("lock_enter_f_ready", f_ready, 1'b1);
        step();
        applyStimulus(1'b1, ALU_PLUS, 32'd2, 32'd2, 1'b1, ALU_PLUS, 32'd1, 32'd1, 1'b1);
        for (int k = 0; k < 8; k++) begin
            #1;
            checkFlag($sformatf("lock%0d_c_ready", k), c_ready, 1'b0);
            checkFlag($sformatf("lock%0d_f_ready", k), f_ready, 1'b1);
            step();
        end
        #1;
        checkFlag("lock_release_c_ready", c_ready, 1'b1);
        checkFlag("lock_release_f_ready", f_ready, 1'b0);
        step();

        // Core response backpressure with two transactions in flight
        resetDut();
        c_rsp_ready = 1'b0;
        applyStimulus(1'b1, ALU_PLUS, 32'd1, 32'd2, 1'b0, ALU_PLUS, 32'd0, 32'd0, 1'b0);
        #1;
        checkFlag("bp_acc0", c_ready, 1'b1);
        step();
        applyStimulus(1'b1, ALU_PLUS, 32'd3, 32'd4, 1'b0, ALU_PLUS, 32'd0, 32'd0, 1'b0);
        #1;
        checkFlag("bp_acc1", c_ready, 1'b1);
        step();
        applyStimulus(1'b1, ALU_PLUS, 32'd10, 32'd20, 1'b0, ALU_PLUS, 32'd0, 32'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            checkFlag($sformatf("bp_hold%0d_valid", k), c_rsp_valid, 1'b1);
            checkOutput($sformatf("bp_hold%0d_data", k), rsp_data, 32'd3);
            checkFlag($sformatf("bp_hold%0d_c_ready", k), c_ready, 1'b0);
            step();
        end
        c_rsp_ready = 1'b1;
        #1;
        checkOutput("bp_rel_data0", rsp_data, 32'd3);
        checkFlag("bp_rel_c_ready", c_ready, 1'b1);
        step();
        idle();
        #1;
        checkFlag("bp_rel_valid1", c_rsp_valid, 1'b1);
        checkOutput("bp_rel_data1", rsp_data, 32'd7);
        step();
        #1;
        checkOutput("bp_rel_data2", rsp_data, 32'd30);
        step();
        #1;
        checkFlag("bp_drained", c_rsp_valid, 1'b0);

        // F branch result, then reset while a locked F op is in flight
        resetDut();
        applyStimulus(1'b0, ALU_PLUS, 32'd0, 32'd0, 1'b1, ALU_BEQ, 32'd9, 32'd9, 1'b1);
        #1;
        checkFlag("br_f_ready0", f_ready, 1'b1);
        step();
        applyStimulus(1'b0, ALU_PLUS, 32'd0, 32'd0, 1'b1, ALU_BEQ, 32'd9, 32'd8, 1'b1);
        #1;
        checkFlag("br_f_ready1", f_ready, 1'b1);
        step();
        idle();
        #1;
        checkFlag("br_f_rsp_valid", f_rsp_valid, 1'b1);
        checkFlag("br_rsp_zero", rsp_zero, 1'b1);
        rst_n = 1'b0;
        applyStimulus(1'b1, ALU_PLUS, 32'd1, 32'd1, 1'b0, ALU_PLUS, 32'd0, 32'd0, 1'b0);
        step();
        checkFlag("rst_c_rsp_valid", c_rsp_valid, 1'b0);
        checkFlag("rst_f_rsp_valid", f_rsp_valid, 1'b0);
        checkFlag("rst_c_ready", c_ready, 1'b0);
        checkFlag("rst_f_ready", f_ready, 1'b0);
        checkOutput("rst_alu_src1", alu_src1, 32'd0);
        checkOutput("rst_rsp_data", rsp_data, 32'd0);
        checkFlag("rst_rsp_zero", rsp_zero, 1'b0);
        rst_n = 1'b1;
        #1;
        checkFlag("post_rst_c_ready", c_ready, 1'b1);
        checkFlag("post_rst_f_ready", f_ready, 1'b0);
        step();
        idle();
        #1;
        checkFlag("post_rst_no_f_rsp", f_rsp_valid, 1'b0);
        step();
        #1;
        checkFlag("post_rst_c_rsp", c_rsp_valid, 1'b1);
        checkOutput("post_rst_data", rsp_data, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
